// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencing controller: per-latch advance/bubble/hold decisions,
// sticky halt and saturating stall/flush counters.
//
// state  | meaning
// RUN    | normal issue; hazards resolved combinationally each cycle
// DWAIT  | data memory miss outstanding; pipeline frozen until dhit
// HALTED | HALT retired; everything frozen until nRST
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             memdren,
  input  logic             memdwen,
  input  logic             memhalt,
  input  logic             exbranch,
  input  logic             exload,
  input  logic [4:0]       exwsel,
  input  logic [4:0]       idrs,
  input  logic [4:0]       idrt,
  output logic             pcW,
  output logic             ifidW,
  output logic             ifidRST,
  output logic             idexW,
  output logic             idexRST,
  output logic             exmemW,
  output logic             exmemRST,
  output logic             memwbW,
  output logic             memwbRST,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_next;
  logic   dpend, luh;
  logic   do_up, do_rel, flush_evt, stall_evt;

  assign dpend = memdren | memdwen;
  assign luh   = exload && (exwsel != 5'd0) && ((exwsel == idrs) || (exwsel == idrt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (memhalt)            state_next = HALTED;
        else if (dpend && !dhit) state_next = DWAIT;
      end
      DWAIT:   if (dhit) state_next = RUN;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pcW = 1'b0; ifidW = 1'b0; ifidRST = 1'b0; idexW = 1'b0; idexRST = 1'b0;
    exmemW = 1'b0; exmemRST = 1'b0; memwbW = 1'b0; memwbRST = 1'b0;
    do_up = 1'b0; do_rel = 1'b0; flush_evt = 1'b0;
    if (!nRST) begin
      ifidRST = 1'b1; idexRST = 1'b1; exmemRST = 1'b1; memwbRST = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (memhalt)    memwbW = 1'b1;
          else if (dpend) do_rel = dhit;
          else            do_up  = 1'b1;
        end
        DWAIT:   do_rel = dhit;
        default: ;
      endcase
      // Without ihit the released data op must not re-issue, so EX/MEM is bubbled.
      if (do_rel) begin
        memwbW = 1'b1;
        if (ihit) do_up = 1'b1;
        else      exmemRST = 1'b1;
      end
      if (do_up) begin
        if (exbranch) begin
          if (ihit) begin
            pcW = 1'b1; ifidRST = 1'b1; idexRST = 1'b1;
            exmemW = 1'b1; memwbW = 1'b1; flush_evt = 1'b1;
          end
        end else if (luh || !ihit) begin
          idexRST = 1'b1; exmemW = 1'b1; memwbW = 1'b1;
        end else begin
          pcW = 1'b1; ifidW = 1'b1; idexW = 1'b1; exmemW = 1'b1; memwbW = 1'b1;
        end
      end
    end
  end

  assign stall_evt = (state != HALTED) && !pcW;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == RUN && memhalt) halt <= 1'b1;
      if (stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
